// File: rtl/mmio_counter_ctrl.sv
// mmio_counter_ctrl
//
// Memory-mapped performance counter block for the memory stage. It decodes
// MMIO loads and stores in the counter window and owns four counters:
// cycle, retired instruction, retired branch and correctly predicted branch.
// Load data is registered, so it arrives one cycle after the request, the
// same as DMem. A store to the reset word clears all four counters.
//
// Register map (byte offsets from BASE_ADDR, word aligned):
//   +0x00 cycle (RO)   +0x04 instruction (RO)   +0x08 reset (WO)
//   +0x0C branch (RO)  +0x10 correct prediction (RO)
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous reset, active low
//   addr           MMIO byte address, qualified by re/we
//   re / we        load / store request this cycle (store data unused)
//   inst_retire    one instruction retired this cycle
//   branch_retire  the retired instruction is a conditional branch
//   branch_correct that branch was predicted correctly
//   hit            combinational: addr is a mapped word and re|we is high
//   rdata          registered load data
//   rvalid         registered; high in the cycle rdata is valid
//
// Build option: define MMIO_CNTR_SATURATE_EN to make every counter stick at
// its all-ones value instead of wrapping. Without it, counters wrap mod 2^W.

module mmio_counter_ctrl #(
    parameter int          CNTR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic                  re,
    input  logic                  we,
    input  logic                  inst_retire,
    input  logic                  branch_retire,
    input  logic                  branch_correct,
    output logic                  hit,
    output logic [CNTR_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    localparam logic [2:0] SEL_CYC  = 3'd0;
    localparam logic [2:0] SEL_INST = 3'd1;
    localparam logic [2:0] SEL_RST  = 3'd2;
    localparam logic [2:0] SEL_BR   = 3'd3;
    localparam logic [2:0] SEL_BRC  = 3'd4;
    localparam logic [2:0] SEL_NONE = 3'd7;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    // Next value of one counter given its increment enable.
    function automatic logic [CNTR_WIDTH-1:0] cnt_next(
        input logic [CNTR_WIDTH-1:0] cur,
        input logic                  inc
    );
        if (!inc) begin
            return cur;
        end
`ifdef MMIO_CNTR_SATURATE_EN
        if (cur == {CNTR_WIDTH{1'b1}}) begin
            return cur;
        end
`endif
        return cur + CNT_ONE;
    endfunction

    logic [CNTR_WIDTH-1:0] cyc_q;
    logic [CNTR_WIDTH-1:0] inst_q;
    logic [CNTR_WIDTH-1:0] br_q;
    logic [CNTR_WIDTH-1:0] brc_q;

    logic [2:0]            sel_p0;
    logic                  clear_p0;
    logic                  load_p0;
    logic [CNTR_WIDTH-1:0] rd_val_p0;

    logic [CNTR_WIDTH-1:0] rdata_p1;
    logic                  vld_p1;

    // ---- Stage p0: address decode and read mux (combinational) ----
    // Exact word compares only, so any address with addr[1:0] != 0 misses.
    always_comb begin
        sel_p0 = SEL_NONE;
        if (addr == BASE_ADDR) begin
            sel_p0 = SEL_CYC;
        end else if (addr == BASE_ADDR + 32'h4) begin
            sel_p0 = SEL_INST;
        end else if (addr == BASE_ADDR + 32'h8) begin
            sel_p0 = SEL_RST;
        end else if (addr == BASE_ADDR + 32'hC) begin
            sel_p0 = SEL_BR;
        end else if (addr == BASE_ADDR + 32'h10) begin
            sel_p0 = SEL_BRC;
        end
    end

    assign hit      = (sel_p0 != SEL_NONE) && (re || we);
    assign clear_p0 = we && (sel_p0 == SEL_RST);
    assign load_p0  = re && (sel_p0 != SEL_NONE);

    // The mux reads the counters as they stand this cycle, so a load that
    // coincides with a clear still returns the pre-clear value. The reset
    // word is write-only and reads back as zero.
    always_comb begin
        rd_val_p0 = '0;
        case (sel_p0)
            SEL_CYC:  rd_val_p0 = cyc_q;
            SEL_INST: rd_val_p0 = inst_q;
            SEL_BR:   rd_val_p0 = br_q;
            SEL_BRC:  rd_val_p0 = brc_q;
            default:  rd_val_p0 = '0;
        endcase
    end

    // ---- Counter state ----
    // Clear wins over this cycle's increments, including the cycle count,
    // so the first cycle after the clearing store observes cyc == 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q  <= '0;
            inst_q <= '0;
            br_q   <= '0;
            brc_q  <= '0;
        end else if (clear_p0) begin
            cyc_q  <= '0;
            inst_q <= '0;
            br_q   <= '0;
            brc_q  <= '0;
        end else begin
            cyc_q  <= cnt_next(cyc_q, 1'b1);
            inst_q <= cnt_next(inst_q, inst_retire);
            br_q   <= cnt_next(br_q, branch_retire);
            brc_q  <= cnt_next(brc_q, branch_retire && branch_correct);
        end
    end

    // ---- Stage p1: registered load response ----
    // Data is forced to zero whenever no valid load completes, so a miss or
    // an idle cycle never leaves stale counter values on rdata.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else if (load_p0) begin
            vld_p1   <= 1'b1;
            rdata_p1 <= rd_val_p0;
        end else begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end
    end

    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;

endmodule

// File: tb/tb_mmio_counter_ctrl.sv
// Testbench for mmio_counter_ctrl: a table of per-cycle vectors drives the
// main flow (counting, loads, clear, decode misses), followed by hand-written
// sequences for counter overflow (on a 4-bit instance) and mid-run reset.

module tb_mmio_counter_ctrl;

    localparam logic [31:0] B = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        re, we, inst_retire, branch_retire, branch_correct;
    logic        hit, rvalid;
    logic [31:0] rdata;
    logic        n_hit, n_rvalid;
    logic [3:0]  n_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmio_counter_ctrl #(.CNTR_WIDTH(32), .BASE_ADDR(B)) dut (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we),
        .inst_retire(inst_retire), .branch_retire(branch_retire),
        .branch_correct(branch_correct),
        .hit(hit), .rdata(rdata), .rvalid(rvalid)
    );

    // Narrow copy sharing the same stimulus, used to reach overflow quickly.
    mmio_counter_ctrl #(.CNTR_WIDTH(4), .BASE_ADDR(B)) dut_n (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we),
        .inst_retire(inst_retire), .branch_retire(branch_retire),
        .branch_correct(branch_correct),
        .hit(n_hit), .rdata(n_rdata), .rvalid(n_rvalid)
    );

    typedef struct {
        logic [31:0] a;
        logic        re, we, ir, br, bc;
        logic        exp_hit;
        logic        exp_vld;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic r, input logic w,
                       input logic ir, input logic br, input logic bc,
                       input logic eh, input logic ev, input logic [31:0] ed);
        vec_t v;
        v.a = a; v.re = r; v.we = w; v.ir = ir; v.br = br; v.bc = bc;
        v.exp_hit = eh; v.exp_vld = ev; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] a, input logic r, input logic w,
                         input logic ir, input logic br, input logic bc);
        addr = a; re = r; we = w;
        inst_retire = ir; branch_retire = br; branch_correct = bc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full cycle: drive, check hit, clock, check the registered response.
    task automatic run_cycle(input string name, input logic [31:0] a,
                             input logic r, input logic w, input logic ir,
                             input logic br, input logic bc, input logic eh,
                             input logic ev, input logic [31:0] ed);
        drive(a, r, w, ir, br, bc);
        #1;
        check({name, ".hit"}, {31'b0, hit}, {31'b0, eh});
        tick();
        check({name, ".rvalid"}, {31'b0, rvalid}, {31'b0, ev});
        check({name, ".rdata"}, rdata, ed);
    endtask

    initial begin
        // Cycle k after reset release: cyc == k.
        for (int i = 0; i < 10; i++) add(32'h0, 0, 0, 1, 0, 0, 0, 0, 0);  // 0-9
        add(B + 32'h4,  1, 0, 0, 0, 0, 1, 1, 32'd10);   // 10 inst
        add(B,          1, 0, 0, 0, 0, 1, 1, 32'd11);   // 11 cyc
        add(32'h0,      0, 0, 0, 1, 1, 0, 0, 0);        // 12
        add(32'h0,      0, 0, 0, 1, 1, 0, 0, 0);        // 13
        add(32'h0,      0, 0, 0, 1, 0, 0, 0, 0);        // 14
        add(32'h0,      0, 0, 0, 1, 1, 0, 0, 0);        // 15
        add(32'h0,      0, 0, 0, 1, 0, 0, 0, 0);        // 16
        add(32'h0,      0, 0, 0, 0, 1, 0, 0, 0);        // 17 correct alone
        add(B + 32'hC,  1, 0, 0, 0, 0, 1, 1, 32'd5);    // 18 br
        add(B + 32'h10, 1, 0, 0, 0, 0, 1, 1, 32'd3);    // 19 brc
        add(B + 32'h4,  1, 0, 0, 0, 0, 1, 1, 32'd10);   // 20 inst
        add(B,          1, 0, 0, 0, 0, 1, 1, 32'd21);   // 21 cyc
        add(B + 32'h8,  0, 1, 1, 1, 1, 1, 0, 0);        // 22 clear, all incs high
        add(B,          1, 0, 0, 0, 0, 1, 1, 32'd0);    // 23
        add(B + 32'h4,  1, 0, 0, 0, 0, 1, 1, 32'd0);    // 24
        add(B + 32'hC,  1, 0, 0, 0, 0, 1, 1, 32'd0);    // 25
        add(B + 32'h10, 1, 0, 0, 0, 0, 1, 1, 32'd0);    // 26
        add(B,          1, 0, 0, 0, 0, 1, 1, 32'd4);    // 27
        add(32'h8000_0024, 1, 0, 0, 0, 0, 0, 0, 0);     // 28 beyond window
        add(32'h8000_0011, 1, 0, 0, 0, 0, 0, 0, 0);     // 29 misaligned
        add(B + 32'h8,  1, 0, 0, 0, 0, 1, 1, 32'd0);    // 30 load of reset word
        add(B,          0, 1, 1, 0, 0, 1, 0, 0);        // 31 store to RO: no effect
        add(B,          1, 0, 0, 0, 0, 1, 1, 32'd9);    // 32
        add(B + 32'h4,  1, 0, 0, 0, 0, 1, 1, 32'd1);    // 33
        add(B + 32'h8,  1, 1, 0, 0, 0, 1, 1, 32'd0);    // 34 re+we on reset word
        add(B,          1, 0, 0, 0, 0, 1, 1, 32'd0);    // 35
        add(32'h8000_0019, 0, 1, 0, 0, 0, 0, 0, 0);     // 36 misaligned store
        add(B,          1, 0, 0, 0, 0, 1, 1, 32'd2);    // 37 not cleared
        add(B,          0, 0, 0, 0, 0, 0, 0, 0);        // 38 no request, no hit

        // Reset
        drive(32'h0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        tick();
        check("reset.rvalid", {31'b0, rvalid}, 32'd0);
        check("reset.rdata", rdata, 32'd0);
        check("reset.hit", {31'b0, hit}, 32'd0);

        rst = 1'b1;
        foreach (vecs[i]) begin
            run_cycle($sformatf("vec%0d", i), vecs[i].a, vecs[i].re,
                      vecs[i].we, vecs[i].ir, vecs[i].br, vecs[i].bc,
                      vecs[i].exp_hit, vecs[i].exp_vld, vecs[i].exp_data);
        end

        // Overflow: clear at cycle 39, so cycle 40 + k sees cyc == k.
        run_cycle("ovf.clear", B + 32'h8, 0, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) begin
            drive(32'h0, 0, 0, 1, 0, 0);
            tick();
        end
        run_cycle("ovf.c15", B, 1, 0, 0, 0, 0, 1, 1, 32'd15);
        check("ovf.n15.rvalid", {31'b0, n_rvalid}, 32'd1);
        check("ovf.n15.rdata", {28'b0, n_rdata}, 32'd15);
        run_cycle("ovf.c16", B, 1, 0, 0, 0, 0, 1, 1, 32'd16);
`ifdef MMIO_CNTR_SATURATE_EN
        check("ovf.n16.rdata", {28'b0, n_rdata}, 32'd15);
`else
        check("ovf.n16.rdata", {28'b0, n_rdata}, 32'd0);
`endif
        check("ovf.n16.rvalid", {31'b0, n_rvalid}, 32'd1);
        run_cycle("ovf.inst", B + 32'h4, 1, 0, 0, 0, 0, 1, 1, 32'd15);

        // Reset during a load: the load is dropped and counters are zeroed.
        rst = 1'b0;
        drive(B + 32'h4, 1, 0, 1, 1, 1);
        tick();
        check("mrst.rvalid", {31'b0, rvalid}, 32'd0);
        check("mrst.rdata", rdata, 32'd0);
        check("mrst.n.rvalid", {31'b0, n_rvalid}, 32'd0);
        rst = 1'b1;
        run_cycle("mrst.cyc",  B,           1, 0, 0, 0, 0, 1, 1, 32'd0);
        run_cycle("mrst.inst", B + 32'h4,   1, 0, 0, 0, 0, 1, 1, 32'd0);
        run_cycle("mrst.br",   B + 32'hC,   1, 0, 0, 0, 0, 1, 1, 32'd0);
        run_cycle("mrst.brc",  B + 32'h10,  1, 0, 0, 0, 0, 1, 1, 32'd0);
        run_cycle("mrst.cyc4", B,           1, 0, 0, 0, 0, 1, 1, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
